// File: rtl/dma_init_sequencer_if.sv
// Init-task handshake between the DMA init sequencer and the register writer.
// The master raises one-hot init_req; the slave pulses the matching init_fin bit.
interface dma_init_sequencer_if #(
  parameter int TASK_CNT = 8
);
  logic [TASK_CNT-1:0] init_req;
  logic [TASK_CNT-1:0] init_fin;

  modport master (
    output init_req,
    input  init_fin
  );

  modport slave (
    input  init_req,
    output init_fin
  );
endinterface

// File: rtl/dma_init_sequencer.sv
// Walks the masked init-task vector in ascending order, one writer request at a time,
// with per-task timeout, completion pulse and saturating sequence cycle profile.
module dma_init_sequencer #(
  parameter int TASK_CNT       = 8,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PROFILE_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TASK_CNT-1:0]      task_mask,
  input  logic                     clear_err,
  dma_init_sequencer_if.master     init,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [IDX_WIDTH-1:0]     err_task_idx,
  output logic [IDX_WIDTH-1:0]     tasks_done,
  output logic [PROFILE_WIDTH-1:0] seq_cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [IDX_WIDTH-1:0] IDX_END =
    IDX_WIDTH'(TASK_CNT);
  localparam logic [TIMEOUT_WIDTH-1:0] WCNT_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TASK_CNT-1:0] ONE =
    {{(TASK_CNT-1){1'b0}}, 1'b1};

  logic [2:0]               state;
  logic [IDX_WIDTH-1:0]     idx;
  logic [TIMEOUT_WIDTH-1:0] wcnt;
  logic [TASK_CNT-1:0]      mask;
  logic [TASK_CNT-1:0]      onehot;
  logic                     sel;
  logic                     fin_hit;
  logic [PROFILE_WIDTH-1:0] seq_next;

  // onehot is zero once idx reaches TASK_CNT
  assign onehot   = ONE << idx;
  assign sel      = |(mask & onehot);
  assign fin_hit  = |(init.init_fin & init.init_req);
  assign seq_next = (&seq_cycles) ? seq_cycles
                                  : seq_cycles + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      wcnt          <= '0;
      mask          <= '0;
      init.init_req <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_task_idx  <= '0;
      tasks_done    <= '0;
      seq_cycles    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mask         <= task_mask;
            idx          <= '0;
            tasks_done   <= '0;
            seq_cycles   <= '0;
            err_task_idx <= '0;
            busy         <= 1'b1;
            state        <= S_SCAN;
          end
        end
        S_SCAN: begin
          seq_cycles <= seq_next;
          if (idx == IDX_END) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (sel) begin
            init.init_req <= onehot;
            wcnt          <= '0;
            state         <= S_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WAIT: begin
          seq_cycles <= seq_next;
          // an ack on the final count still completes the task
          if (fin_hit) begin
            init.init_req <= '0;
            idx           <= idx + 1'b1;
            tasks_done    <= tasks_done + 1'b1;
            state         <= S_SCAN;
          end else if (wcnt == WCNT_LAST) begin
            init.init_req <= '0;
            err_task_idx  <= idx;
            err           <= 1'b1;
            state         <= S_ERR;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          if (clear_err) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_init_sequencer.sv
// Randomized scoreboard bench for dma_init_sequencer with a delayed-ack writer model.
// Expected request order and end-of-sequence results come from a task-list model.
module tb_dma_init_sequencer;
  localparam int TC = 8;
  localparam int IW = 4;
  localparam int TW = 16;
  localparam int TO = 1024;
  localparam int PW = 32;

  typedef struct {
    bit is_err;
    int tasks;
    int eidx;
    int cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [TC-1:0] task_mask;
  logic          clear_err;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW-1:0] err_task_idx;
  logic [IW-1:0] tasks_done;
  logic [PW-1:0] seq_cycles;

  dma_init_sequencer_if #(.TASK_CNT(TC)) bus ();

  dma_init_sequencer #(
    .TASK_CNT(TC), .IDX_WIDTH(IW), .TIMEOUT_WIDTH(TW),
    .TIMEOUT_CYCLES(TO), .PROFILE_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .task_mask(task_mask), .clear_err(clear_err),
    .init(bus.master), .busy(busy), .done(done),
    .err(err), .err_task_idx(err_task_idx),
    .tasks_done(tasks_done), .seq_cycles(seq_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int accept_cyc = 0;
  int req_rise_cyc = 0;
  int ack_dly [TC];
  int stall_idx = -1;
  logic [TC-1:0] req_q [$];
  exp_t exp_q [$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, expv);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic int idx_of(input logic [TC-1:0] r);
    int k = -1;
    for (int i = 0; i < TC; i++)
      if (r[i]) k = i;
    return k;
  endfunction

  // writer: acks ack_dly[t] cycles after req, with noise on other bits
  initial begin : writer
    logic [TC-1:0] r;
    int t;
    bus.init_fin = '0;
    forever begin
      @(posedge clk); #1;
      if (reset && bus.init_req != '0) begin
        r = bus.init_req;
        t = idx_of(r);
        if (t == stall_idx) begin
          while (bus.init_req != '0) begin
            bus.init_fin = TC'($urandom) & ~r;
            @(posedge clk); #1;
          end
          bus.init_fin = '0;
        end else begin
          repeat (ack_dly[t] - 1) begin
            bus.init_fin = TC'($urandom) & ~r;
            @(posedge clk); #1;
          end
          bus.init_fin = r;
          @(posedge clk); #1;
          bus.init_fin = '0;
        end
      end
    end
  end

  initial begin : monitor
    logic [TC-1:0] prev_req;
    logic prev_done;
    logic prev_err;
    exp_t e;
    prev_req  = '0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.init_req != '0 && prev_req == '0) begin
          req_rise_cyc = cyc;
          if (req_q.size() == 0) note_fail("req_unexpected");
          else chk("req_order", bus.init_req, req_q.pop_front());
        end
        if (done && prev_done) note_fail("done_width");
        if (done && !prev_done) begin
          if (exp_q.size() == 0) note_fail("done_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("done_vs_err", 0, e.is_err);
            chk("tasks_done", tasks_done, e.tasks);
            chk("seq_cycles", seq_cycles, e.cycles);
            chk("elapsed", cyc - accept_cyc, e.cycles);
            chk("req_left", req_q.size(), 0);
            chk("done_err", err, 0);
          end
        end
        if (err && !prev_err) begin
          if (exp_q.size() == 0) note_fail("err_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("err_vs_done", 1, e.is_err);
            chk("err_task_idx", err_task_idx, e.eidx);
            chk("err_tasks_done", tasks_done, e.tasks);
            chk("err_req", bus.init_req, 0);
            chk("err_wait", cyc - req_rise_cyc, TO);
          end
        end
      end
      prev_req  = bus.init_req;
      prev_done = done;
      prev_err  = err;
    end
  end

  task automatic run_seq(input logic [TC-1:0] m,
                         input int stall,
                         input int dmax,
                         input int sp_idx,
                         input int sp_dly,
                         input bit poke);
    exp_t e;
    logic [TC-1:0] one = 1;
    bit fin = 0;
    for (int i = 0; i < TC; i++)
      ack_dly[i] = $urandom_range(dmax, 1);
    if (sp_idx >= 0) ack_dly[sp_idx] = sp_dly;
    stall_idx = stall;
    e = '{0, 0, 0, TC + 1};
    for (int i = 0; i < TC; i++) begin
      if (m[i] && !e.is_err) begin
        req_q.push_back(one << i);
        if (i == stall) begin
          e.is_err = 1;
          e.eidx = i;
        end else begin
          e.tasks++;
          e.cycles += ack_dly[i];
        end
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    task_mask = m;
    @(posedge clk); #1;
    accept_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    task_mask = TC'($urandom);
    chk("busy_run", busy, 1);
    for (int k = 0; k < 5000; k++) begin
      if (poke && k == 10) begin
        start = 1'b1;
        task_mask = ~m;
      end else begin
        start = 1'b0;
      end
      if (!busy || err) begin
        fin = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) note_fail("seq_timeout");
    if (err) begin
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("clr_busy", busy, 0);
      chk("clr_err", err, 0);
      chk("err_idx_held", err_task_idx, e.eidx);
    end
    repeat (2) @(negedge clk);
    stall_idx = -1;
  endtask

  initial begin : stim
    logic [TC-1:0] m;
    int bound;
    reset = 1'b0;
    start = 1'b0;
    clear_err = 1'b0;
    task_mask = '0;
    for (int i = 0; i < TC; i++) ack_dly[i] = 1;
    #12;
    chk("rst_req", bus.init_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tasks", tasks_done, 0);
    chk("rst_cycles", seq_cycles, 0);
    chk("rst_eidx", err_task_idx, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(8'hFF, -1, 4, 0, 4, 0);
    for (int i = 0; i < TC; i++) ack_dly[i] = 4;
    run_seq(8'hA5, -1, 6, -1, 0, 0);
    run_seq(8'h00, -1, 3, -1, 0, 0);
    run_seq(8'h0F, 2, 3, -1, 0, 0);
    run_seq(8'h0F, -1, 3, 0, TO, 1);
    for (int n = 0; n < 8; n++) begin
      m = TC'($urandom);
      run_seq(m, (n == 5) ? idx_of(m) : -1,
              7, -1, 0, 0);
    end

    // async reset while task 3 waits
    stall_idx = 3;
    for (int i = 0; i < 3; i++) ack_dly[i] = 2;
    for (int i = 0; i < 4; i++)
      req_q.push_back(TC'(1) << i);
    @(negedge clk);
    start = 1'b1;
    task_mask = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    bound = 0;
    while (bus.init_req != 8'h08 && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 200) note_fail("task3_wait");
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_req", bus.init_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_tasks", tasks_done, 0);
    chk("arst_cycles", seq_cycles, 0);
    req_q.delete();
    exp_q.delete();
    stall_idx = -1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_seq(8'hFF, -1, 3, -1, 0, 0);

    chk("exp_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
